// File: rtl/smss32_gf_pkg.sv
// rtl/smss32_gf_pkg.sv - GF(2^6) tower/normal-basis helpers and FSM state type for the inverse SMSS32 S-box
package smss32_gf_pkg;

    localparam int LANE_W = 6;

    typedef logic [2:0] gf8_t;
    typedef logic [5:0] gf64_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // nu in t^2 + t + nu; trace one, so the tower polynomial is irreducible over GF(2^3)
    localparam gf8_t GF_NU = 3'b001;

    // GF(2^3) normal basis {b, b^2, b^4} with b^3 = b^2 + 1; bit i is the coefficient of b^(2^i)
    function automatic gf8_t gf8_add(gf8_t a, gf8_t b);
        return a ^ b;
    endfunction

    function automatic gf8_t gf8_mul(gf8_t a, gf8_t b);
        gf8_t c;
        c[0] = (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]) ^ (a[2] & b[2]);
        c[1] = (a[0] & b[0]) ^ (a[0] & b[2]) ^ (a[2] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
        c[2] = (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[2]) ^ (a[2] & b[0]) ^ (a[1] & b[1]);
        return c;
    endfunction

    function automatic gf8_t gf8_sq(gf8_t a);
        return {a[1], a[0], a[2]};
    endfunction

    function automatic gf8_t gf8_fourth(gf8_t a);
        return {a[0], a[2], a[1]};
    endfunction

    // Tower element {hi, lo} = hi*g^8 + lo*g, with g + g^8 = 1 and g*g^8 = nu
    function automatic gf64_t gf64_mul(gf64_t a, gf64_t b);
        gf8_t e;
        e = gf8_mul(GF_NU, gf8_mul(gf8_add(a[5:3], a[2:0]), gf8_add(b[5:3], b[2:0])));
        return {gf8_mul(a[5:3], b[5:3]) ^ e, gf8_mul(a[2:0], b[2:0]) ^ e};
    endfunction

    function automatic gf64_t gf64_sq(gf64_t a);
        gf8_t e;
        e = gf8_mul(GF_NU, gf8_sq(gf8_add(a[5:3], a[2:0])));
        return {gf8_sq(a[5:3]) ^ e, gf8_sq(a[2:0]) ^ e};
    endfunction

    function automatic gf64_t gf64_frob(gf64_t a);
        return {a[2:0], a[5:3]};
    endfunction

    function automatic gf64_t l2inv(logic [5:0] x);
        gf64_t p;
        p[0] = x[0] ^ x[1] ^ x[4];
        p[1] = x[0] ^ x[2] ^ x[3] ^ x[4] ^ x[5];
        p[2] = x[0] ^ x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[5];
        p[3] = x[1] ^ x[5];
        p[4] = x[1] ^ x[3] ^ x[5];
        p[5] = x[4] ^ x[5];
        return p;
    endfunction

    function automatic logic [5:0] l1inv(gf64_t w);
        logic [5:0] y;
        y[0] = w[0] ^ w[4] ^ w[5];
        y[1] = w[2] ^ w[3] ^ w[4] ^ w[5];
        y[2] = w[2] ^ w[3];
        y[3] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5];
        y[4] = w[3] ^ w[5];
        y[5] = w[0] ^ w[2] ^ w[3] ^ w[4];
        return y;
    endfunction

endpackage

// File: rtl/smss32_inv_sbox_word_if.sv
// rtl/smss32_inv_sbox_word_if.sv - valid/ready word bus; lane_mask exists only with SMSS32_INV_LANE_MASK_EN
interface smss32_inv_sbox_word_if
    import smss32_gf_pkg::*;
#(
    parameter int LANES = 6
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANE_W*LANES-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANE_W*LANES-1:0]   out_data;
`ifdef SMSS32_INV_LANE_MASK_EN
    logic [LANES-1:0]          lane_mask;
`endif

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
`ifdef SMSS32_INV_LANE_MASK_EN
        output lane_mask,
`endif
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
`ifdef SMSS32_INV_LANE_MASK_EN
        input  lane_mask,
`endif
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/smss32_inv_sbox_core.sv
// rtl/smss32_inv_sbox_core.sv - combinational 6-bit inverse SMSS32 S-box: L1inv((L2inv(x))^5)
module smss32_inv_sbox_core
    import smss32_gf_pkg::*;
(
    input  logic [LANE_W-1:0] x,
    output logic [LANE_W-1:0] y
);
    gf64_t w;
    gf64_t w4;
    gf64_t p5;

    // w^5 = (w^2)^2 * w: two linear squarings and a single tower multiply
    assign w  = l2inv(x);
    assign w4 = gf64_sq(gf64_sq(w));
    assign p5 = gf64_mul(w4, w);
    assign y  = l1inv(p5);
endmodule

// File: rtl/smss32_inv_sbox_word.sv
// rtl/smss32_inv_sbox_word.sv - LANES-lane inverse S-box word, one core per lane per cycle; option SMSS32_INV_LANE_MASK_EN
module smss32_inv_sbox_word
    import smss32_gf_pkg::*;
#(
    parameter int LANES = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    smss32_inv_sbox_word_if.slave   bus
);
    localparam int W     = LANE_W * LANES;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       hold_q, hold_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [LANE_W-1:0]  lane_x;
    logic [LANE_W-1:0]  lane_y;
    logic [LANE_W-1:0]  lane_res;
`ifdef SMSS32_INV_LANE_MASK_EN
    logic [LANES-1:0]   mask_q, mask_d;
    logic               lane_skip;
`endif

    always_comb begin
        lane_x = '0;
`ifdef SMSS32_INV_LANE_MASK_EN
        lane_skip = 1'b0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                lane_x = hold_q[i*LANE_W +: LANE_W];
`ifdef SMSS32_INV_LANE_MASK_EN
                lane_skip = mask_q[i];
`endif
            end
        end
    end

    smss32_inv_sbox_core u_core (
        .x (lane_x),
        .y (lane_y)
    );

`ifdef SMSS32_INV_LANE_MASK_EN
    assign lane_res = lane_skip ? lane_x : lane_y;
`else
    assign lane_res = lane_y;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SMSS32_INV_LANE_MASK_EN
        mask_d      = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    hold_d     = bus.in_data;
`ifdef SMSS32_INV_LANE_MASK_EN
                    mask_d     = bus.lane_mask;
`endif
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < LANES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        out_data_d[i*LANE_W +: LANE_W] = lane_res;
                    end
                end
                // idx parks on the last lane; the next accept reloads it
                if (idx_q == IDX_W'(LANES - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SMSS32_INV_LANE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SMSS32_INV_LANE_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_smss32_inv_sbox_word.sv
// tb/tb_smss32_inv_sbox_word.sv - self-checking bench for smss32_inv_sbox_word (optionally SMSS32_INV_LANE_MASK_EN)
module tb_smss32_inv_sbox_word;
    localparam int LANES = 6;
    localparam int W     = 6 * LANES;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [5:0] l1_t   [64];
    logic [5:0] l2_t   [64];
    logic [5:0] s_t    [64];
    logic [5:0] inv_t  [64];
    logic [5:0] exp_t  [63];
    int         log_t  [64];

    smss32_inv_sbox_word_if #(.LANES(LANES)) bus ();

    smss32_inv_sbox_word #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^3) via polynomial basis mod x^3+x^2+1; normal-basis bit i stands for b^(2^i)
    function automatic logic [2:0] nb2poly(input logic [2:0] a);
        logic [2:0] r;
        r = 3'b000;
        if (a[0]) r = r ^ 3'b010;
        if (a[1]) r = r ^ 3'b100;
        if (a[2]) r = r ^ 3'b111;
        return r;
    endfunction

    function automatic logic [2:0] poly2nb(input logic [2:0] p);
        logic [2:0] r;
        r = 3'b000;
        for (int v = 0; v < 8; v++) begin
            if (nb2poly(3'(v)) == p) r = 3'(v);
        end
        return r;
    endfunction

    function automatic logic [2:0] bm8(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        logic [2:0] pa;
        logic [2:0] pb;
        pa = nb2poly(a);
        pb = nb2poly(b);
        p  = 5'b0;
        for (int i = 0; i < 3; i++) begin
            if (pb[i]) p = p ^ ({2'b00, pa} << i);
        end
        for (int i = 4; i >= 3; i--) begin
            if (p[i]) p = p ^ (5'b01101 << (i - 3));
        end
        return poly2nb(p[2:0]);
    endfunction

    // GF(2^6) as GF(8)[t]/(t^2+t+nu), element = c0 + c1*g
    function automatic logic [5:0] bm64(input logic [5:0] a, input logic [5:0] b);
        logic [2:0] c0, c1, d0, d1, r0, r1, nu;
        nu = 3'b001;
        c0 = a[5:3];
        c1 = a[5:3] ^ a[2:0];
        d0 = b[5:3];
        d1 = b[5:3] ^ b[2:0];
        r0 = bm8(c0, d0) ^ bm8(bm8(c1, d1), nu);
        r1 = bm8(c0, d1) ^ bm8(c1, d0) ^ bm8(c1, d1);
        return {r0, r0 ^ r1};
    endfunction

    function automatic logic [5:0] f_l2inv(input logic [5:0] x);
        return {x[4] ^ x[5], x[1] ^ x[3] ^ x[5], x[1] ^ x[5], ^x,
                x[0] ^ x[2] ^ x[3] ^ x[4] ^ x[5], x[0] ^ x[1] ^ x[4]};
    endfunction

    function automatic logic [5:0] f_l1inv(input logic [5:0] w);
        return {w[0] ^ w[2] ^ w[3] ^ w[4], w[3] ^ w[5], ^w, w[2] ^ w[3],
                w[2] ^ w[3] ^ w[4] ^ w[5], w[0] ^ w[4] ^ w[5]};
    endfunction

    function automatic logic [W-1:0] model_word(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*6 +: 6] = inv_t[d[i*6 +: 6]];
        return r;
    endfunction

    task automatic build_model();
        logic [5:0] p;
        int         gen;
        int         k;
        for (int v = 0; v < 64; v++) begin
            l1_t[f_l1inv(6'(v))] = 6'(v);
            l2_t[f_l2inv(6'(v))] = 6'(v);
        end
        gen = 2;
        for (int c = 63; c >= 2; c--) begin
            p = 6'(c);
            k = 1;
            while (p != 6'h3F && k < 64) begin
                p = bm64(p, 6'(c));
                k++;
            end
            if (k == 63) gen = c;
        end
        p = 6'h3F;
        for (int i = 0; i < 63; i++) begin
            exp_t[i] = p;
            log_t[p] = i;
            p = bm64(p, 6'(gen));
        end
        for (int x = 0; x < 64; x++) begin
            p = l1_t[x];
            if (p != 6'h00) p = exp_t[(log_t[p] * 38) % 63];
            s_t[x] = l2_t[p];
            inv_t[l2_t[p]] = 6'(x);
        end
    endtask

    task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] e, input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (n === LANES) else begin
            errors++;
            $error("FAIL %s_latency observed=%0d expected=%0d", tag, n, LANES);
        end
        checks++;
        assert (bus.out_data === e) else begin
            errors++;
            $error("FAIL %s_data observed=%h expected=%h", tag, bus.out_data, e);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        assert (bus.out_valid === 1'b0) else begin
            errors++;
            $error("FAIL %s_valid_drop observed=%b expected=0", tag, bus.out_valid);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] e;
        logic [63:0]  r64;
        int           n;
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef SMSS32_INV_LANE_MASK_EN
        bus.lane_mask = '0;
`endif
        build_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert (bus.in_ready === 1'b1 && bus.out_valid === 1'b0 && bus.out_data === '0) else begin
            errors++;
            $error("FAIL reset_state observed=%b%b_%h expected=10_%h", bus.in_ready, bus.out_valid, bus.out_data, {W{1'b0}});
        end

        // T1 / T2 directed words
        run_word(36'h0, 36'h0, "t1_zero");
        run_word({6{6'h25}}, {6{6'h01}}, "t2_all25");
        run_word(36'h000000025, 36'h000000001, "t2_lane0");

        // T3 every value through the forward S-box returns to itself
        for (int j = 0; j < 11; j++) begin
            for (int i = 0; i < LANES; i++) begin
                d[i*6 +: 6] = s_t[(j * LANES + i) % 64];
                e[i*6 +: 6] = 6'((j * LANES + i) % 64);
            end
            run_word(d, e, $sformatf("t3_w%0d", j));
        end

        // random words against the inverse table
        for (int j = 0; j < 16; j++) begin
            r64 = {$urandom, $urandom};
            d = r64[W-1:0];
            run_word(d, model_word(d), $sformatf("rand_%0d", j));
        end

        // T4 backpressure in DONE with a stray in_valid pulse
        d = {6'h3F, 6'h11, 6'h2A, 6'h05, 6'h30, 6'h1C};
        e = model_word(d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.in_data  = ~d;
            checks++;
            assert (bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.out_data === e) else begin
                errors++;
                $error("FAIL t4_hold_c%0d observed=%b%b_%h expected=10_%h", c, bus.out_valid, bus.in_ready, bus.out_data, e);
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        assert (bus.out_valid === 1'b0 && bus.in_ready === 1'b1) else begin
            errors++;
            $error("FAIL t4_release observed=%b%b expected=01", bus.out_valid, bus.in_ready);
        end
        d = {6{6'h25}};
        run_word(d, {6{6'h01}}, "t4_next");

        // T5 asynchronous reset at idx=3
        bus.in_valid = 1'b1;
        bus.in_data  = {6{6'h25}};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (bus.out_valid === 1'b0 && bus.out_data === '0) else begin
            errors++;
            $error("FAIL t5_reset observed=%b_%h expected=0_%h", bus.out_valid, bus.out_data, {W{1'b0}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert (bus.in_ready === 1'b1 && bus.out_valid === 1'b0) else begin
            errors++;
            $error("FAIL t5_release observed=%b%b expected=10", bus.in_ready, bus.out_valid);
        end
        r64 = {$urandom, $urandom};
        d = r64[W-1:0];
        run_word(d, model_word(d), "t5_next");

`ifdef SMSS32_INV_LANE_MASK_EN
        // T6 masked lane passes through unchanged
        bus.lane_mask = 6'b000010;
        run_word({6{6'h25}}, {6'h01, 6'h01, 6'h01, 6'h01, 6'h25, 6'h01}, "t6_mask");
        bus.lane_mask = 6'b101001;
        d = {6'h10, 6'h22, 6'h3A, 6'h07, 6'h19, 6'h2E};
        e = model_word(d);
        e[0 +: 6]  = d[0 +: 6];
        e[18 +: 6] = d[18 +: 6];
        e[30 +: 6] = d[30 +: 6];
        run_word(d, e, "t6_mask2");
        bus.lane_mask = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
